// File: rtl/program_loader.sv
// Bring-up loader for the 9-bit CPU: streams an image into IM/DM, pulses start, waits for done.
// Optional watchdog enabled by defining LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int IM_SIZE   = 64,
  parameter int DM_SIZE   = 64,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [8:0]  ld_data,
  input  logic        ld_sel,
  input  logic        ld_last,
  input  logic        rerun,
  input  logic        reload,
  output logic        im_wr_en,
  output logic [9:0]  im_addr,
  output logic [8:0]  im_wr_data,
  output logic        dm_wr_en,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wr_data,
  output logic        start,
  input  logic        done,
  output logic        busy,
  output logic        finished,
  output logic        overflow,
`ifdef LOADER_TIMEOUT_EN
  output logic        timed_out,
`endif
  output logic [31:0] cycles
);

  localparam int IPW = $clog2(IM_SIZE + 1);
  localparam int DPW = $clog2(DM_SIZE + 1);
  localparam int AW  = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  if (START_CYC < 1) begin : g_bad_sc
    $error("START_CYC must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IPW-1:0]  im_ptr_q;
  logic [DPW-1:0]  dm_ptr_q;
  logic [AW-1:0]   arm_cnt_q;
  logic [31:0]     cycles_q, cyc_inc;
  logic            ld_ready_q, start_q, busy_q, finished_q, overflow_q, to_q;
  logic            im_wr_en_q, dm_wr_en_q;
  logic [9:0]      im_addr_q;
  logic [8:0]      im_wr_data_q;
  logic [7:0]      dm_addr_q, dm_wr_data_q;
  logic            accept, im_full, dm_full, to_hit;

  always_comb begin
    accept  = ld_valid & ld_ready_q & (state_q == S_IDLE);
    im_full = (im_ptr_q == IPW'(IM_SIZE));
    dm_full = (dm_ptr_q == DPW'(DM_SIZE));
    cyc_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
`ifdef LOADER_TIMEOUT_EN
    to_hit  = (cyc_inc == 32'(TIMEOUT));
`else
    to_hit  = 1'b0;
`endif
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && ld_last) state_d = S_ARM;
      S_ARM:  if (arm_cnt_q == AW'(START_CYC - 1)) state_d = S_RUN;
      S_RUN:  if (done || to_hit) state_d = S_DONE;
      S_DONE: begin
        if (reload)     state_d = S_IDLE;
        else if (rerun) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ld_ready_q   <= 1'b0;
      start_q      <= 1'b1;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      overflow_q   <= 1'b0;
      to_q         <= 1'b0;
      im_ptr_q     <= '0;
      dm_ptr_q     <= '0;
      arm_cnt_q    <= '0;
      cycles_q     <= '0;
      im_wr_en_q   <= 1'b0;
      im_addr_q    <= '0;
      im_wr_data_q <= '0;
      dm_wr_en_q   <= 1'b0;
      dm_addr_q    <= '0;
      dm_wr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= (state_d == S_IDLE);
      start_q    <= (state_d != S_RUN);
      busy_q     <= (state_d == S_ARM) || (state_d == S_RUN);
      finished_q <= (state_d == S_DONE);
      im_wr_en_q <= 1'b0;
      dm_wr_en_q <= 1'b0;

      // A beat hitting a full memory is swallowed; the pointer parks at SIZE.
      if (accept) begin
        if (!ld_sel) begin
          if (im_full) overflow_q <= 1'b1;
          else begin
            im_wr_en_q   <= 1'b1;
            im_addr_q    <= 10'(im_ptr_q);
            im_wr_data_q <= ld_data;
            im_ptr_q     <= im_ptr_q + 1'b1;
          end
        end else begin
          if (dm_full) overflow_q <= 1'b1;
          else begin
            dm_wr_en_q   <= 1'b1;
            dm_addr_q    <= 8'(dm_ptr_q);
            dm_wr_data_q <= ld_data[7:0];
            dm_ptr_q     <= dm_ptr_q + 1'b1;
          end
        end
      end

      if (state_q != S_ARM && state_d == S_ARM) begin
        arm_cnt_q <= '0;
        cycles_q  <= '0;
        to_q      <= 1'b0;
      end else if (state_q == S_ARM) begin
        arm_cnt_q <= arm_cnt_q + 1'b1;
      end

      // done wins over the watchdog and its cycle is not counted.
      if (state_q == S_RUN && !done) begin
        cycles_q <= cyc_inc;
        if (to_hit) to_q <= 1'b1;
      end

      if (state_q == S_DONE && reload) begin
        im_ptr_q   <= '0;
        dm_ptr_q   <= '0;
        overflow_q <= 1'b0;
        cycles_q   <= '0;
        to_q       <= 1'b0;
      end
    end
  end

  assign ld_ready   = ld_ready_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign overflow   = overflow_q;
  assign cycles     = cycles_q;
  assign im_wr_en   = im_wr_en_q;
  assign im_addr    = im_addr_q;
  assign im_wr_data = im_wr_data_q;
  assign dm_wr_en   = dm_wr_en_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wr_data = dm_wr_data_q;
`ifdef LOADER_TIMEOUT_EN
  assign timed_out  = to_q;
`else
  logic unused_to;
  assign unused_to  = to_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes/completions, a monitor pops them.
module tb_program_loader;
  localparam int IMS = 4, DMS = 4, SC = 2, TO = 20;

  logic        clk = 1'b0;
  logic        reset, ld_valid, ld_sel, ld_last, rerun, reload, done;
  logic [8:0]  ld_data;
  logic        ld_ready, im_wr_en, dm_wr_en, start, busy, finished, overflow;
  logic [9:0]  im_addr;
  logic [8:0]  im_wr_data;
  logic [7:0]  dm_addr, dm_wr_data;
  logic [31:0] cycles;
  logic        to_val;
`ifdef LOADER_TIMEOUT_EN
  logic        timed_out;
  assign to_val = timed_out;
`else
  assign to_val = 1'b0;
`endif

  program_loader #(.IM_SIZE(IMS), .DM_SIZE(DMS), .START_CYC(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_sel(ld_sel), .ld_last(ld_last), .rerun(rerun), .reload(reload),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wr_data(im_wr_data),
    .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .start(start), .done(done), .busy(busy), .finished(finished), .overflow(overflow),
`ifdef LOADER_TIMEOUT_EN
    .timed_out(timed_out),
`endif
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  typedef struct { int kind; int a; int d; } ev_t;
  ev_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int a, input int d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    expq.push_back(e);
  endtask

  task automatic pop_chk(input int k, input int a, input int d);
    ev_t e;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d a %0h d %0h want none", k, a, d);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.a != a || e.d != d) begin
        miscompares++;
        $display("FAIL event: got kind %0d a %0h d %0h want kind %0d a %0h d %0h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: each write or rising finished consumes one expected event.
  logic fin_prev = 1'b0;
  always @(negedge clk) begin
    if (im_wr_en) pop_chk(0, int'(im_addr), int'(im_wr_data));
    if (dm_wr_en) pop_chk(1, int'(dm_addr), int'(dm_wr_data));
    if (finished && !fin_prev) pop_chk(2, int'(cycles), int'(to_val));
    fin_prev = finished;
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // exp_addr < 0 means the beat must be dropped.
  task automatic send(input logic sel, input logic [8:0] d, input logic last,
                      input int exp_addr, input int exp_data);
    chk("ld_ready_before_beat", {31'b0, ld_ready}, 32'd1);
    if (exp_addr >= 0) push(int'(sel), exp_addr, exp_data);
    ld_valid = 1'b1; ld_sel = sel; ld_data = d; ld_last = last;
    step;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic finish_run(input int nodone, input int exp_cyc);
    push(2, exp_cyc, 0);
    repeat (nodone) step;
    done = 1'b1; step; done = 1'b0;
    chk("finished", {31'b0, finished}, 32'd1);
    chk("start_in_done", {31'b0, start}, 32'd1);
    chk("cycles_done", cycles, 32'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_last = 1'b0;
    rerun = 1'b0; reload = 1'b0; done = 1'b0; ld_data = '0;
    step; step;
    chk("rst_start", {31'b0, start}, 32'd1);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_finished", {31'b0, finished}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_im_addr", {22'b0, im_addr}, 32'd0);
    reset = 1'b0; step;
    chk("idle_ld_ready", {31'b0, ld_ready}, 32'd1);

    // Three instruction words, then ARM for 2 cycles
    send(1'b0, 9'h1A0, 1'b0, 0, 'h1A0);
    send(1'b0, 9'h055, 1'b0, 1, 'h055);
    send(1'b0, 9'h1FF, 1'b1, 2, 'h1FF);
    chk("ready_after_last", {31'b0, ld_ready}, 32'd0);
    chk("arm1_start", {31'b0, start}, 32'd1);
    chk("arm1_busy", {31'b0, busy}, 32'd1);
    step;
    chk("arm2_start", {31'b0, start}, 32'd1);
    step;
    chk("run_start", {31'b0, start}, 32'd0);
    chk("run_busy", {31'b0, busy}, 32'd1);
    finish_run(9, 9);

    // rerun (with reload low) restarts ARM and clears cycles
    rerun = 1'b1; step; rerun = 1'b0;
    chk("rerun_cycles", cycles, 32'd0);
    chk("rerun_start", {31'b0, start}, 32'd1);
    chk("rerun_finished", {31'b0, finished}, 32'd0);
    step;
    chk("rerun_arm2_start", {31'b0, start}, 32'd1);
    step;
    chk("rerun_run_start", {31'b0, start}, 32'd0);
    finish_run(0, 0);

    // reload and rerun together: reload wins
    reload = 1'b1; rerun = 1'b1; step; reload = 1'b0; rerun = 1'b0;
    chk("reload_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("reload_busy", {31'b0, busy}, 32'd0);
    chk("reload_cycles", cycles, 32'd0);

    // Mixed image; bit 8 of a data beat is discarded
    send(1'b0, 9'h0F0, 1'b0, 0, 'h0F0);
    send(1'b1, 9'h1AB, 1'b0, 0, 'hAB);
    send(1'b0, 9'h00F, 1'b0, 1, 'h00F);
    send(1'b1, 9'h0CD, 1'b1, 1, 'hCD);
    chk("mixed_overflow", {31'b0, overflow}, 32'd0);
    ld_valid = 1'b1; ld_data = 9'h123;  // ignored in ARM
    step; step;
    ld_valid = 1'b0;
    finish_run(2, 2);
    reload = 1'b1; step; reload = 1'b0;

    // Six instruction beats into a 4-deep IM
    send(1'b0, 9'h001, 1'b0, 0, 'h001);
    send(1'b0, 9'h002, 1'b0, 1, 'h002);
    send(1'b0, 9'h003, 1'b0, 2, 'h003);
    send(1'b0, 9'h004, 1'b0, 3, 'h004);
    send(1'b0, 9'h005, 1'b0, -1, 0);
    send(1'b0, 9'h006, 1'b1, -1, 0);
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    step; step;
    chk("ovf_run_start", {31'b0, start}, 32'd0);
    repeat (3) step;
    chk("ovf_run_cycles", cycles, 32'd3);

    // Reset mid-run
    reset = 1'b1; step; reset = 1'b0;
    chk("mrun_start", {31'b0, start}, 32'd1);
    chk("mrun_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("mrun_busy", {31'b0, busy}, 32'd0);
    chk("mrun_cycles", cycles, 32'd0);
    chk("mrun_overflow", {31'b0, overflow}, 32'd0);
    step;
    chk("mrun_ready_back", {31'b0, ld_ready}, 32'd1);

    // Reset mid-stream: next image starts again at address 0
    send(1'b0, 9'h111, 1'b0, 0, 'h111);
    send(1'b0, 9'h122, 1'b0, 1, 'h122);
    reset = 1'b1; step; reset = 1'b0;
    chk("mstr_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("mstr_start", {31'b0, start}, 32'd1);
    step;
    send(1'b0, 9'h133, 1'b1, 0, 'h133);
    step; step;
`ifdef LOADER_TIMEOUT_EN
    begin
      int k;
      push(2, TO, 1);
      k = 0;
      while (!finished && k < 100) begin step; k++; end
      chk("to_reached", {31'b0, finished}, 32'd1);
      chk("to_cycles", cycles, 32'(TO));
      chk("to_flag", {31'b0, timed_out}, 32'd1);
      rerun = 1'b1; step; rerun = 1'b0;
      chk("to_clr_on_arm", {31'b0, timed_out}, 32'd0);
      step; step;
      finish_run(TO - 1, TO - 1);
      chk("to_done_wins", {31'b0, timed_out}, 32'd0);
    end
`else
    finish_run(3, 3);
`endif
    step; step;
    chk("queue_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream bring-up stage for the 9-bit CPU: accepts a stream of program words and data bytes over a valid/ready port, writes them into instruction and data memory, then drives the CPU `start` line and waits for `done`. It holds the CPU in reset (`start` high) whenever it is not running, counts execution cycles, and reports completion. It sits between the test harness/host link and the CPU's `start`/`done` pins and memory write ports.

## Interface
- `IM_SIZE`, 64: instruction memory depth in 9-bit words.
- `DM_SIZE`, 64: data memory depth in bytes.
- `START_CYC`, 2: number of cycles `start` is held high in ARM before release; minimum 1.
- `TIMEOUT`, 100000: watchdog limit in RUN cycles. Used only when `LOADER_TIMEOUT_EN` is defined.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `ld_valid` in 1: a load beat is present.
- `ld_ready` out 1: the loader accepts the beat.
- `ld_data` in 9: beat payload.
- `ld_sel` in 1: 0 = instruction word, 1 = data byte (`ld_data[7:0]`).
- `ld_last` in 1: final beat of the image.
- `rerun` in 1: in DONE, re-run the loaded program without reloading.
- `reload` in 1: in DONE, return to IDLE to accept a new image.
- `im_wr_en` out 1, `im_addr` out 10, `im_wr_data` out 9: instruction memory write port.
- `dm_wr_en` out 1, `dm_addr` out 8, `dm_wr_data` out 8: data memory write port.
- `start` out 1: CPU start/reset. High holds the CPU; low lets it run.
- `done` in 1: CPU completion flag.
- `busy` out 1: state is ARM or RUN.
- `finished` out 1: state is DONE.
- `overflow` out 1: sticky flag, set when a beat was dropped because its memory was full.
- `cycles` out 32: number of RUN cycles observed with `done` low.
- `timed_out` out 1: the run ended by watchdog. Present only with `LOADER_TIMEOUT_EN`.

## Operation
- States: IDLE, ARM, RUN, DONE.
- Reset values:
  - State goes to IDLE.
  - `start`=1, `ld_ready`=0 for the first cycle after reset.
  - All write enables 0; addresses and data 0.
  - Pointers 0; `cycles` 0; `overflow`, `finished`, `busy`, `timed_out` all 0.
- IDLE:
  - `ld_ready`=1 and `start`=1.
  - A beat is accepted when `ld_valid & ld_ready`.
  - `ld_sel`=0 writes `im[im_ptr]` and increments `im_ptr`. `ld_sel`=1 writes `dm[dm_ptr]` and increments `dm_ptr`.
  - Pointers are wide enough to hold `SIZE`. A beat arriving with its pointer == SIZE is accepted and dropped: no write, `overflow` set, pointer held (no wrap).
  - An accepted beat with `ld_last`=1 is still written (unless dropped), then the state goes to ARM.
- ARM:
  - `ld_ready`=0, `start`=1.
  - Lasts exactly `START_CYC` cycles, then the state goes to RUN.
  - `cycles` is cleared on entry.
- RUN:
  - `start`=0.
  - Each cycle with `done`=0 increments `cycles`, saturating at all-ones.
  - `done`=1 sampled in RUN moves the state to DONE. That cycle is not counted.
- DONE:
  - `start`=1 (CPU held) and `finished`=1; `cycles` is frozen.
  - `reload` moves the state to IDLE, clears both pointers, `overflow`, and `cycles`.
  - `rerun` moves the state to ARM; memories are not rewritten.
  - If both are asserted, `reload` wins.
- `rerun`, `reload`, and `ld_valid` are ignored outside the states listed above.
- `reset` in any state, including mid-load or mid-run, returns everything to reset values the next cycle. Memory contents are not cleared.

## Timing
- Memory writes are registered. The write enable, address, and data are asserted the cycle after beat acceptance, for exactly one cycle.
- Back-to-back beats are accepted one per cycle with no bubbles.
- `ld_ready` falls the cycle after the `ld_last` beat is accepted.
- `start` falls `START_CYC` cycles after ARM entry. For the first beat, `start` stays high at least until the final write has been issued.
- `done` to `finished`: 1 cycle. `start` rises on the same edge that `finished` rises.
- All outputs are registered; there are no combinational input-to-output paths except none.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - In RUN, if `cycles` reaches `TIMEOUT` with `done` still 0, the state goes to DONE with `timed_out`=1 and `start`=1.
  - `timed_out` is cleared on ARM entry and on `reload`.
  - `done` and the timeout in the same cycle: `done` wins and `timed_out`=0.
- Not defined: no watchdog, no `timed_out` port, and RUN waits indefinitely.

## Test plan
- Reset, then stream 3 instruction words (0x1A0, 0x055, 0x1FF with `ld_last`) -> `im` writes at addresses 0, 1, 2 on consecutive cycles; ARM lasts 2 cycles; `start` goes 1→0.
- Mixed image of 2 instruction words and 2 data bytes (0xAB, 0xCD), interleaved -> `im` addresses 0, 1; `dm` addresses 0, 1 with data 0xAB, 0xCD; `overflow`=0.
- With `IM_SIZE`=4, send 6 instruction beats -> 4 writes, 2 dropped, `overflow`=1, `im_addr` never exceeds 3.
- `done` raised on the 10th RUN cycle -> `cycles`=9, `finished`=1, and `start`=1 one cycle later. Then `rerun` -> `cycles`=0 again, and RUN re-entered after 2 cycles.
- `reset` asserted mid-RUN and mid-stream -> the next cycle shows IDLE, `start`=1, `ld_ready`=0 for that cycle only, `cycles`=0, and pointers at 0.
- With `LOADER_TIMEOUT_EN` and `TIMEOUT`=20, hold `done`=0 -> DONE entered after 20 counted cycles with `timed_out`=1. `done`=1 arriving on cycle 20 instead -> `timed_out`=0.
